regfile_bank: RTL and testbench
===============================

Name: regfile_bank

Overview:
- 32-entry x 32-bit architectural register storage with one write port and two read ports.
- Holds the values consumed by the 32:1 read-select stage; the read-select is instantiated internally, once per read port.
- Adds a per-register pending scoreboard. Issue marks a destination busy; write-back clears it. Read-side hazard flags let the pipeline stall on operands not yet written back.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- NUM_REGS, 32, number of registers; fixed at 32, with 5-bit register addresses.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked pending.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ctrl_write_enable  input  1  write-back strobe.
- ctrl_write_reg  input  5  write-back destination register.
- data_write  input  DATA_WIDTH  write-back data.
- issue_valid  input  1  an instruction with a destination issues this cycle.
- issue_dest  input  5  destination register of the issuing instruction.
- ctrl_read_a  input  5  read port A address.
- ctrl_read_b  input  5  read port B address.
- data_read_a  output  DATA_WIDTH  port A data, combinational.
- data_read_b  output  DATA_WIDTH  port B data, combinational.
- hazard_a  output  1  register addressed on port A is pending.
- hazard_b  output  1  register addressed on port B is pending.
- pending_count  output  6  number of registers currently pending (0..32).

Behaviour:
- Reset (reset_n low, asynchronous): all registers clear to 0 and all pending bits clear.
  - Consequences: data_read_a/b = 0, hazard_a/b = 0, pending_count = 0.
  - Reset asserted mid-operation discards in-flight writes and issues in that cycle.
- Write: on a rising edge with ctrl_write_enable=1, data_write is stored in reg[ctrl_write_reg].
  - With ZERO_REG=1, a write to reg 0 is dropped.
- Read: data_read_x = reg[ctrl_read_x] through a 32:1 selection, purely combinational.
  - Without the bypass feature, a write in the same cycle is not visible until the cycle after the edge.
- Scoreboard, per register i, one bit pending[i], updated on the rising edge:
  - Set when issue_valid=1 and issue_dest=i.
  - Cleared when ctrl_write_enable=1 and ctrl_write_reg=i.
  - Simultaneous issue and write to the same i: the bit stays set, because the new producer takes precedence over the completing one.
  - With ZERO_REG=1, pending[0] is constant 0.
- hazard_x = pending[ctrl_read_x], combinational, subject to the bypass rule in Optional Feature.
- pending_count: registered population count of pending[], updated on the same edge as pending[]. It never wraps; the 6-bit width covers 32.
- Issue of an already-pending register keeps the bit set; there is no count of outstanding producers.
- A write to a non-pending register is legal: data is stored and the scoreboard is unchanged.
- Both read ports may address the same register.
- No other internal state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first forwarding): when ctrl_write_enable=1 and ctrl_read_x == ctrl_write_reg, with the register nonzero if ZERO_REG=1:
  - data_read_x = data_write in the same cycle.
  - hazard_x = 0 in that cycle, unless issue_valid=1 with issue_dest equal to the same register, in which case hazard_x = 1.
- Undefined: no forwarding.
  - Reads return stored values only.
  - hazard_x reflects pending[] as registered, so an operand completing this cycle stalls one extra cycle.

Test Plan:
- Reset: drive reset_n low for 2 cycles mid-stream after writing reg5=0xDEADBEEF -> data_read_a (addr 5)=0, hazard_a=0, pending_count=0, with no clock edge needed.
- Write/read: write reg7=0x12345678, then next cycle read A=7, B=7 -> both ports return 0x12345678; write reg0=0xFFFFFFFF -> reading reg0 returns 0.
- Scoreboard: issue dest=9 -> next cycle hazard_a=1 (A=9), pending_count=1; write-back reg9=0xA5A5A5A5 -> following cycle hazard_a=0, count=0, data=0xA5A5A5A5.
- Collision: reg3 pending, then same cycle write reg3 and issue dest=3 -> pending[3] remains 1, hazard on reg3 stays 1, count unchanged.
- Fill: issue dests 1..31 on consecutive cycles -> pending_count reaches 31; issue dest=0 -> count stays 31.
- Bypass (REGFILE_BYPASS_EN defined): reg4 pending, read A=4 while writing reg4=0x0BADF00D -> same cycle data_read_a=0x0BADF00D, hazard_a=0. Undefined: same cycle data_read_a=old value, hazard_a=1.

Source files
------------

// File: rtl/regfile_bank.sv
// regfile_bank: 32 x DATA_WIDTH architectural register file with one write
// port, two combinational read ports and a per-register pending scoreboard.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   ctrl_write_enable       write-back strobe
//   ctrl_write_reg          write-back destination (5 bits)
//   data_write              write-back data
//   issue_valid/issue_dest  an instruction with destination issue_dest issues
//   ctrl_read_a/_b          read addresses
//   data_read_a/_b          combinational read data
//   hazard_a/_b             addressed register has a pending producer
//   pending_count           registered number of pending registers (0..32)
//
// Issue and write-back are single-cycle strobes with no back-pressure: each is
// sampled on every rising edge where its enable is high and is always accepted.
//
// Optional feature (macro REGFILE_BYPASS_EN): write-first forwarding from the
// write port to both read ports, including the hazard flags.

module regfile_read_sel #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic [4:0]                     addr,
  output logic [DATA_WIDTH-1:0]          data
);
  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == i[4:0]) data = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

module regfile_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ctrl_write_enable,
  input  logic [4:0]            ctrl_write_reg,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_dest,
  input  logic [4:0]            ctrl_read_a,
  input  logic [4:0]            ctrl_read_b,
  output logic [DATA_WIDTH-1:0] data_read_a,
  output logic [DATA_WIDTH-1:0] data_read_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic [5:0]            pending_count
);
  logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0]            pending_next;
  logic [5:0]                     count_next;
  logic                           write_ok;
  logic [DATA_WIDTH-1:0]          sel_a;
  logic [DATA_WIDTH-1:0]          sel_b;

  // Register 0 is hardwired when ZERO_REG is set, so its writes are dropped.
  assign write_ok = ctrl_write_enable && !(ZERO_REG != 0 && ctrl_write_reg == 5'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[ctrl_write_reg] <= data_write;
    end
  end

  // Clear first, then set: a new producer issuing on the same edge as the old
  // one writes back must keep the register pending.
  always_comb begin
    pending_next = pending;
    if (ctrl_write_enable) pending_next[ctrl_write_reg] = 1'b0;
    if (issue_valid)       pending_next[issue_dest]     = 1'b1;
    if (ZERO_REG != 0)     pending_next[0]              = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) count_next = count_next + {5'd0, pending_next[i]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_next;
      pending_count <= count_next;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  regfile_read_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_sel_a (
    .regs_flat (regs_flat),
    .addr      (ctrl_read_a),
    .data      (sel_a)
  );

  regfile_read_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_sel_b (
    .regs_flat (regs_flat),
    .addr      (ctrl_read_b),
    .data      (sel_b)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // write_ok already excludes register 0 when it is hardwired.
  assign fwd_a = write_ok && (ctrl_write_reg == ctrl_read_a);
  assign fwd_b = write_ok && (ctrl_write_reg == ctrl_read_b);

  // A forwarded operand is ready unless a newer producer issues this cycle.
  always_comb begin
    data_read_a = fwd_a ? data_write : sel_a;
    data_read_b = fwd_b ? data_write : sel_b;
    hazard_a    = fwd_a ? (issue_valid && issue_dest == ctrl_read_a) : pending[ctrl_read_a];
    hazard_b    = fwd_b ? (issue_valid && issue_dest == ctrl_read_b) : pending[ctrl_read_b];
  end
`else
  always_comb begin
    data_read_a = sel_a;
    data_read_b = sel_b;
    hazard_a    = pending[ctrl_read_a];
    hazard_b    = pending[ctrl_read_b];
  end
`endif

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;
  logic        clock;
  logic        reset_n;
  logic        ctrl_write_enable;
  logic [4:0]  ctrl_write_reg;
  logic [31:0] data_write;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic [4:0]  ctrl_read_a;
  logic [4:0]  ctrl_read_b;
  logic [31:0] data_read_a;
  logic [31:0] data_read_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [5:0]  pending_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // expected {data_a, data_b, hazard_a, hazard_b, pending_count}
  logic [71:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  dest;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eha;
    logic        ehb;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[13];

  // reference model for the random phase
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  regfile_bank dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ctrl_write_enable (ctrl_write_enable),
    .ctrl_write_reg    (ctrl_write_reg),
    .data_write        (data_write),
    .issue_valid       (issue_valid),
    .issue_dest        (issue_dest),
    .ctrl_read_a       (ctrl_read_a),
    .ctrl_read_b       (ctrl_read_b),
    .data_read_a       (data_read_a),
    .data_read_b       (data_read_b),
    .hazard_a          (hazard_a),
    .hazard_b          (hazard_b),
    .pending_count     (pending_count)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input string tag);
    logic [71:0] e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".data_a"}, data_read_a, e[71:40]);
      chk({tag, ".data_b"}, data_read_b, e[39:8]);
      chk({tag, ".hazard_a"}, {31'd0, hazard_a}, {31'd0, e[7]});
      chk({tag, ".hazard_b"}, {31'd0, hazard_b}, {31'd0, e[6]});
      chk({tag, ".count"}, {26'd0, pending_count}, {26'd0, e[5:0]});
    end
  endtask

  // driver: apply one cycle of inputs just after the falling edge
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic iv, input logic [4:0] dest,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    ctrl_write_enable = we;
    ctrl_write_reg    = wr;
    data_write        = wd;
    issue_valid       = iv;
    issue_dest        = dest;
    ctrl_read_a       = ra;
    ctrl_read_b       = rb;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic eha, input logic ehb, input logic [5:0] ecnt);
    exp_q.push_back({ea, eb, eha, ehb, ecnt});
    check_out(tag);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ctrl_write_enable = 1'b0;
    issue_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ctrl_write_enable = 1'b0;
    ctrl_write_reg = '0;
    data_write = '0;
    issue_valid = 1'b0;
    issue_dest = '0;
    ctrl_read_a = 5'd0;
    ctrl_read_b = 5'd31;

    vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0, 5'd0,  5'd1, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 5'd7,  5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd0,  5'd7, 32'h0,        32'h12345678, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd0, 32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
    vecs[4]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 5'd0, 5'd7,  5'd3, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd7,  5'd9, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[7]  = '{1'b1, 5'd3,  32'h11112222, 1'b1, 5'd3, 5'd9,  5'd7, 32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd3, 32'h11112222, 32'h11112222, 1'b1, 1'b1, 6'd1};
    vecs[9]  = '{1'b1, 5'd3,  32'h33334444, 1'b1, 5'd0, 5'd5,  5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd3,  5'd0, 32'h33334444, 32'h0,        1'b0, 1'b0, 6'd0};
    vecs[11] = '{1'b1, 5'd20, 32'hDEAD0020, 1'b0, 5'd0, 5'd5,  5'd3, 32'h0,        32'h33334444, 1'b1, 1'b0, 6'd1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd20, 5'd5, 32'hDEAD0020, 32'h0,        1'b0, 1'b1, 6'd1};

    // reset state, checked while reset is still asserted
    #2;
    expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // table-driven vectors: outputs observed before the edge that applies the row
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].iv, vecs[i].dest, vecs[i].ra, vecs[i].rb);
      exp_q.push_back({vecs[i].ea, vecs[i].eb, vecs[i].eha, vecs[i].ehb, vecs[i].ecnt});
      check_out($sformatf("vec%0d", i));
    end

    // same-cycle write to a read register; reg5 stays pending from the table
    step(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd7, 5'd7);
    step(1'b1, 5'd4, 32'h0BADF00D, 1'b0, 5'd0, 5'd4, 5'd5);
`ifdef REGFILE_BYPASS_EN
    expect_out("bypass_wr", 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 6'd2);
`else
    expect_out("bypass_wr", 32'h00000044, 32'h0, 1'b1, 1'b1, 6'd2);
`endif
    idle(5'd4, 5'd5);
    expect_out("bypass_after", 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 6'd1);
    step(1'b1, 5'd4, 32'h00000055, 1'b1, 5'd4, 5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    expect_out("bypass_reissue", 32'h00000055, 32'h00000055, 1'b1, 1'b1, 6'd1);
`else
    expect_out("bypass_reissue", 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 6'd1);
`endif
    idle(5'd4, 5'd0);
    expect_out("reissue_after", 32'h00000055, 32'h0, 1'b1, 1'b0, 6'd2);

    // asynchronous reset mid-stream
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd0, 5'd0);
    idle(5'd5, 5'd6);
    expect_out("pre_reset", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 6'd2);
    #1 reset_n = 1'b0;
    #1;
    expect_out("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // fill the scoreboard
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd0, 5'd1);
      expect_out($sformatf("fill%0d", i), 32'h0, 32'h0, 1'b0, (i > 1), 6'(i - 1));
    end
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd31);
    expect_out("fill_full", 32'h0, 32'h0, 1'b0, 1'b1, 6'd31);
    step(1'b1, 5'd31, 32'h31313131, 1'b0, 5'd0, 5'd0, 5'd30);
    expect_out("fill_zero_issue", 32'h0, 32'h0, 1'b0, 1'b1, 6'd31);
    idle(5'd31, 5'd0);
    expect_out("fill_writeback", 32'h31313131, 32'h0, 1'b0, 1'b0, 6'd30);

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pend = 32'h0;
    for (int n = 0; n < 300; n++) begin
      logic        we, iv;
      logic [4:0]  wr, dest, ra, rb;
      logic [31:0] wd, ea, eb;
      logic        eha, ehb;
      we   = 1'($urandom_range(0, 1));
      iv   = 1'($urandom_range(0, 1));
      wr   = 5'($urandom_range(0, 31));
      dest = 5'($urandom_range(0, 31));
      ra   = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rb   = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      wd   = $urandom;
      ea = m_regs[ra];
      eb = m_regs[rb];
      eha = m_pend[ra];
      ehb = m_pend[rb];
`ifdef REGFILE_BYPASS_EN
      if (we && wr == ra && ra != 5'd0) begin
        ea = wd;
        eha = iv && dest == ra;
      end
      if (we && wr == rb && rb != 5'd0) begin
        eb = wd;
        ehb = iv && dest == rb;
      end
`endif
      exp_q.push_back({ea, eb, eha, ehb, 6'($countones(m_pend))});
      step(we, wr, wd, iv, dest, ra, rb);
      check_out($sformatf("rand%0d", n));
      if (we && wr != 5'd0) m_regs[wr] = wd;
      if (we) m_pend[wr] = 1'b0;
      if (iv) m_pend[dest] = 1'b1;
      m_pend[0] = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
